// File: rtl/i_alu_share_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : i_alu_share_arb_if
// Description : Bundle of requester, ALU-steering and result-slot signals
//               for the shared I-type ALU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface i_alu_share_arb_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    // Requester side: two issue ports packed by requester index
    logic [1:0]                req_valid;
    logic [1:0]                req_ready;
    logic [1:0][2:0]           req_funct3;
    logic [1:0]                req_b30;
    logic [1:0][XLEN-1:0]      req_rs1;
    logic [1:0][XLEN-1:0]      req_imm;
    logic [1:0][TAG_W-1:0]     req_tag;

    // Shared combinational ALU
    logic [2:0]                alu_funct3;
    logic                      alu_b30;
    logic [XLEN-1:0]           alu_rs1;
    logic [XLEN-1:0]           alu_imm;
    logic [XLEN-1:0]           alu_result;

    // Registered result slot
    logic                      res_valid;
    logic                      res_ready;
    logic                      res_src;
    logic [TAG_W-1:0]          res_tag;
    logic [XLEN-1:0]           res_data;
    logic                      res_illegal;

    // Arbiter view
    modport slave (
        input  req_valid, req_funct3, req_b30, req_rs1, req_imm, req_tag,
        output req_ready,
        output alu_funct3, alu_b30, alu_rs1, alu_imm,
        input  alu_result,
        output res_valid, res_src, res_tag, res_data, res_illegal,
        input  res_ready
    );

    // Environment view: requesters, ALU and result consumer
    modport master (
        output req_valid, req_funct3, req_b30, req_rs1, req_imm, req_tag,
        input  req_ready,
        input  alu_funct3, alu_b30, alu_rs1, alu_imm,
        output alu_result,
        input  res_valid, res_src, res_tag, res_data, res_illegal,
        output res_ready
    );
endinterface
`default_nettype wire

// File: rtl/i_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : i_alu_share_arb
// Description : Round-robin arbiter sharing one combinational I-type ALU
//               between two requesters, with a single registered result
//               slot under valid/ready backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module i_alu_share_arb #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    i_alu_share_arb_if.slave     bus
);

    localparam logic [2:0] c_F3_SLLI = 3'b001;

    logic              r_rr_ptr;
    logic              r_res_valid;
    logic              r_res_src;
    logic [TAG_W-1:0]  r_res_tag;
    logic [XLEN-1:0]   r_res_data;
    logic              r_res_illegal;

    logic              w_any;
    logic              w_winner;
    logic              w_can_issue;
    logic              w_accept;
    logic              w_illegal;

    // Winner selection, handshake and operand steering onto the ALU
    always_comb begin
        w_any       = |bus.req_valid;
        w_winner    = 1'b0;
        case (bus.req_valid)
            2'b01:   w_winner = 1'b0;
            2'b10:   w_winner = 1'b1;
            2'b11:   w_winner = r_rr_ptr;
            default: w_winner = 1'b0;
        endcase

        // Slot can take a new op when empty or being drained this cycle
        w_can_issue = !r_res_valid || bus.res_ready;
        // Nothing is accepted while reset is held
        w_accept    = w_any && w_can_issue && !rst;

        bus.req_ready = 2'b00;
        if (w_accept) begin
            bus.req_ready = w_winner ? 2'b10 : 2'b01;
        end

        bus.alu_funct3 = 3'b000;
        bus.alu_b30    = 1'b0;
        bus.alu_rs1    = '0;
        bus.alu_imm    = '0;
        if (w_any) begin
            bus.alu_funct3 = bus.req_funct3[w_winner];
            bus.alu_b30    = bus.req_b30[w_winner];
            bus.alu_rs1    = bus.req_rs1[w_winner];
            bus.alu_imm    = bus.req_imm[w_winner];
        end

        // SLLI with bit 30 set has no legal meaning
        w_illegal = (bus.alu_funct3 == c_F3_SLLI) && bus.alu_b30;
    end

    // Result slot capture/drain and round-robin pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr      <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_src     <= 1'b0;
            r_res_tag     <= '0;
            r_res_data    <= '0;
            r_res_illegal <= 1'b0;
        end else if (w_accept) begin
            r_rr_ptr      <= ~w_winner;
            r_res_valid   <= 1'b1;
            r_res_src     <= w_winner;
            r_res_tag     <= bus.req_tag[w_winner];
            r_res_data    <= w_illegal ? '0 : bus.alu_result;
            r_res_illegal <= w_illegal;
        end else if (r_res_valid && bus.res_ready) begin
            r_res_valid   <= 1'b0;
        end
    end

    // Registered result fields drive the slot outputs directly
    always_comb begin
        bus.res_valid   = r_res_valid;
        bus.res_src     = r_res_src;
        bus.res_tag     = r_res_tag;
        bus.res_data    = r_res_data;
        bus.res_illegal = r_res_illegal;
    end

endmodule
`default_nettype wire

// File: tb/tb_i_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_i_alu_share_arb
// Description : Scoreboard bench for i_alu_share_arb: directed scenarios
//               followed by randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i_alu_share_arb;

    localparam int XLEN  = 32;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic              src;
        logic [TAG_W-1:0]  tag;
        logic [XLEN-1:0]   data;
        logic              ill;
    } exp_t;

    logic clk;
    logic rst;

    i_alu_share_arb_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    i_alu_share_arb #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    // Requester-side stimulus state (held until accepted)
    logic             pend [2];
    logic [2:0]       f3   [2];
    logic             b30  [2];
    logic [XLEN-1:0]  rs1  [2];
    logic [XLEN-1:0]  imm  [2];
    logic [TAG_W-1:0] tag  [2];
    logic             d_rst;
    logic             d_res_ready;

    // Reference model state: slot occupancy and who has priority on a tie
    logic m_full;
    logic m_prio;

    // Behavioural I-type ALU sitting on the shared ALU port
    always_comb begin
        logic [4:0] sh;
        sh = bus.alu_imm[4:0];
        case (bus.alu_funct3)
            3'b000:  bus.alu_result = bus.alu_rs1 + bus.alu_imm;
            3'b010:  bus.alu_result = {31'b0, $signed(bus.alu_rs1) < $signed(bus.alu_imm)};
            3'b011:  bus.alu_result = {31'b0, bus.alu_rs1 < bus.alu_imm};
            3'b100:  bus.alu_result = bus.alu_rs1 ^ bus.alu_imm;
            3'b110:  bus.alu_result = bus.alu_rs1 | bus.alu_imm;
            3'b111:  bus.alu_result = bus.alu_rs1 & bus.alu_imm;
            3'b001:  bus.alu_result = bus.alu_b30 ? 32'hDEAD_BEEF : (bus.alu_rs1 << sh);
            default: bus.alu_result = bus.alu_b30 ? 32'($signed(bus.alu_rs1) >>> sh)
                                                  : (bus.alu_rs1 >> sh);
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected outcome of one I-type op, straight from the instruction rules
    function automatic exp_t ref_op(input logic s, input logic [2:0] f, input logic b,
                                    input logic [XLEN-1:0] a, input logic [XLEN-1:0] i,
                                    input logic [TAG_W-1:0] t);
        exp_t e;
        int   sh;
        e.src  = s;
        e.tag  = t;
        e.ill  = 1'b0;
        sh     = int'(i[4:0]);
        case (f)
            3'b000: e.data = a + i;
            3'b010: e.data = ($signed(a) < $signed(i)) ? 32'd1 : 32'd0;
            3'b011: e.data = (a < i) ? 32'd1 : 32'd0;
            3'b100: e.data = a ^ i;
            3'b110: e.data = a | i;
            3'b111: e.data = a & i;
            3'b001: begin
                e.ill  = b;
                e.data = b ? 32'd0 : a * (32'd1 << sh);
            end
            default: begin
                e.data = a / (32'd1 << sh);
                if (b && a[31]) e.data = e.data | ~(32'hFFFF_FFFF >> sh);
            end
        endcase
        return e;
    endfunction

    task automatic set_op(input int i, input logic [2:0] f, input logic b,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] im,
                          input logic [TAG_W-1:0] t);
        f3[i] = f; b30[i] = b; rs1[i] = a; imm[i] = im; tag[i] = t; pend[i] = 1'b1;
    endtask

    task automatic rand_op(input int i);
        logic [31:0] r;
        r = $urandom;
        set_op(i, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
               {{20{r[11]}}, r[11:0]}, 4'($urandom_range(0, 15)));
    endtask

    // One clock: drive at negedge, check handshake and steering before posedge
    task automatic cycle();
        logic       any, win, can, acc;
        logic [1:0] exp_rdy;
        @(negedge clk);
        rst           = d_rst;
        bus.res_ready = d_res_ready;
        for (int i = 0; i < 2; i++) begin
            bus.req_valid[i]  = pend[i];
            bus.req_funct3[i] = f3[i];
            bus.req_b30[i]    = b30[i];
            bus.req_rs1[i]    = rs1[i];
            bus.req_imm[i]    = imm[i];
            bus.req_tag[i]    = tag[i];
        end
        #3;
        any     = pend[0] | pend[1];
        win     = (pend[0] && pend[1]) ? m_prio : pend[1];
        can     = !m_full || d_res_ready;
        acc     = any && can && !d_rst;
        exp_rdy = acc ? (win ? 2'b10 : 2'b01) : 2'b00;
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        chk("alu_rs1", 64'(bus.alu_rs1), any ? 64'(rs1[win]) : 64'd0);
        chk("alu_imm", 64'(bus.alu_imm), any ? 64'(imm[win]) : 64'd0);
        chk("alu_funct3", 64'(bus.alu_funct3), any ? 64'(f3[win]) : 64'd0);
        if (d_rst) begin
            m_full = 1'b0;
            m_prio = 1'b0;
            sb.delete();
        end else begin
            if (acc) begin
                sb.push_back(ref_op(win, f3[win], b30[win], rs1[win], imm[win], tag[win]));
                pend[win] = 1'b0;
                m_prio    = ~win;
            end
            m_full = acc || (m_full && !d_res_ready);
        end
    endtask

    task automatic run_until_issued();
        int n;
        n = 0;
        while ((pend[0] || pend[1]) && n < 20) begin
            cycle();
            n++;
        end
        if (pend[0] || pend[1]) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_timeout: got pending=%b%b required 00", pend[1], pend[0]);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        d_res_ready = 1'b1;
        while ((sb.size() != 0 || m_full) && n < 20) begin
            cycle();
            n++;
        end
        cycle();
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: pops the scoreboard on every result handshake, checks stalls
    initial begin
        logic             stall_prev;
        logic             p_src, p_ill;
        logic [TAG_W-1:0] p_tag;
        logic [XLEN-1:0]  p_data;
        exp_t             e;
        stall_prev = 1'b0;
        p_src = 1'b0; p_ill = 1'b0; p_tag = '0; p_data = '0;
        forever begin
            @(negedge clk);
            #3;
            if (rst !== 1'b0) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("stall_valid", 64'(bus.res_valid), 64'd1);
                    chk("stall_src", 64'(bus.res_src), 64'(p_src));
                    chk("stall_tag", 64'(bus.res_tag), 64'(p_tag));
                    chk("stall_data", 64'(bus.res_data), 64'(p_data));
                    chk("stall_illegal", 64'(bus.res_illegal), 64'(p_ill));
                end
                if (bus.res_valid && bus.res_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL spurious_result: got res_valid=1 required no result pending");
                    end else begin
                        e = sb.pop_front();
                        chk("res_src", 64'(bus.res_src), 64'(e.src));
                        chk("res_tag", 64'(bus.res_tag), 64'(e.tag));
                        chk("res_data", 64'(bus.res_data), 64'(e.data));
                        chk("res_illegal", 64'(bus.res_illegal), 64'(e.ill));
                    end
                end
                stall_prev = bus.res_valid && !bus.res_ready;
                p_src  = bus.res_src;
                p_tag  = bus.res_tag;
                p_data = bus.res_data;
                p_ill  = bus.res_illegal;
            end
        end
    end

    // Directed scenarios then randomized traffic
    initial begin
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; f3[i] = '0; b30[i] = 1'b0; rs1[i] = '0; imm[i] = '0; tag[i] = '0;
        end
        m_full = 1'b0; m_prio = 1'b0;
        rst = 1'b1; d_rst = 1'b1; d_res_ready = 1'b1;
        bus.res_ready = 1'b1; bus.req_valid = 2'b00;
        bus.req_funct3 = '0; bus.req_b30 = '0; bus.req_rs1 = '0; bus.req_imm = '0; bus.req_tag = '0;

        // Reset held with both requesters valid: no grants, slot clears
        rand_op(0); rand_op(1);
        cycle(); cycle();
        @(posedge clk); #1;
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_res_src", 64'(bus.res_src), 64'd0);
        chk("rst_res_tag", 64'(bus.res_tag), 64'd0);
        chk("rst_res_data", 64'(bus.res_data), 64'd0);
        chk("rst_res_illegal", 64'(bus.res_illegal), 64'd0);
        d_rst = 1'b0;
        run_until_issued();
        drain();

        // Single ADDI on requester 0
        set_op(0, 3'b000, 1'b0, 32'd5, 32'hFFFF_FFFD, 4'd7);
        cycle();
        drain();

        // Both requesters continuously valid: strict alternation, no bubbles
        rand_op(0); rand_op(1);
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (!pend[0]) rand_op(0);
            if (!pend[1]) rand_op(1);
        end
        pend[0] = 1'b0; pend[1] = 1'b0;
        drain();

        // Backpressure: result held for 3 cycles, then drain and accept together
        rand_op(0);
        cycle();
        d_res_ready = 1'b0;
        rand_op(0); rand_op(1);
        repeat (3) cycle();
        d_res_ready = 1'b1;
        cycle();
        run_until_issued();
        drain();

        // SRAI then SRLI on requester 1
        set_op(1, 3'b101, 1'b1, 32'h8000_0000, 32'd4, 4'd3);
        run_until_issued();
        set_op(1, 3'b101, 1'b0, 32'h8000_0000, 32'd4, 4'd4);
        run_until_issued();
        drain();

        // Illegal encoding, then reset while the result is still held
        d_res_ready = 1'b0;
        set_op(0, 3'b001, 1'b1, 32'h1234_5678, 32'd3, 4'd9);
        cycle();
        cycle();
        d_rst = 1'b1;
        cycle();
        @(posedge clk); #1;
        chk("midrst_res_valid", 64'(bus.res_valid), 64'd0);
        d_rst = 1'b0;
        d_res_ready = 1'b1;
        rand_op(0); rand_op(1);
        run_until_issued();
        drain();

        // Randomized traffic with occasional reset
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) rand_op(i);
            end
            d_res_ready = ($urandom_range(0, 3) != 0);
            d_rst       = ($urandom_range(0, 299) == 0);
            cycle();
        end
        d_rst = 1'b0;
        run_until_issued();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
